// File: rtl/stream_mux_pkg.sv
// Shared types and encodings for the 2:1 packet stream arbiter and its round-robin picker.
package stream_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    LOCK2 = 2'd2
  } state_e;

  // One-hot grant vector: bit 0 = in1, bit 1 = in2.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IN1  = 2'b01;
  localparam logic [1:0] GNT_IN2  = 2'b10;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-request round-robin picker; on a tie the requester that did not win last gets the grant.
module rr_arb2
  import stream_mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_IN1;
      2'b10:   gnt = GNT_IN2;
      2'b11:   gnt = (last_grant == SEL_IN2) ? GNT_IN1 : GNT_IN2;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/stream_arb2x1.sv
// Packet-granular round-robin merge of two valid/ready streams into one registered output beat.
// Latency 1 cycle; input ready follows the grant and is gated by a free or draining output slot.
module stream_arb2x1
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_valid,
  input  logic             in2_last,
  output logic             in2_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             select
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             select_q, select_d;

  logic [1:0] rr_gnt;
  logic [1:0] grant;
  logic       load;
  logic       xfer1, xfer2;

  rr_arb2 u_rr_arb2 (
    .req        ({in2_valid, in1_valid}),
    .last_grant (last_grant_q),
    .gnt        (rr_gnt)
  );

  // Once a multi-beat packet starts, the grant is pinned to its source until the last beat.
  always_comb begin
    grant = GNT_NONE;
    case (state_q)
      IDLE:    grant = rr_gnt;
      LOCK1:   grant = GNT_IN1;
      LOCK2:   grant = GNT_IN2;
      default: grant = GNT_NONE;
    endcase
  end

  assign load      = out_ready | ~out_valid_q;
  assign in1_ready = (grant == GNT_IN1) & load & ~rst;
  assign in2_ready = (grant == GNT_IN2) & load & ~rst;
  assign xfer1     = in1_valid & in1_ready;
  assign xfer2     = in2_valid & in2_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    select_d     = select_q;
    if (xfer1) begin
      out_data_d  = in1_data;
      out_last_d  = in1_last;
      out_valid_d = 1'b1;
      select_d    = SEL_IN1;
      if (in1_last) begin
        state_d      = IDLE;
        last_grant_d = SEL_IN1;
      end else begin
        state_d = LOCK1;
      end
    end else if (xfer2) begin
      out_data_d  = in2_data;
      out_last_d  = in2_last;
      out_valid_d = 1'b1;
      select_d    = SEL_IN2;
      if (in2_last) begin
        state_d      = IDLE;
        last_grant_d = SEL_IN2;
      end else begin
        state_d = LOCK2;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_IN2;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      select_q     <= SEL_IN1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      select_q     <= select_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign select    = select_q;

endmodule

// File: tb/tb_stream_arb2x1.sv
// Randomized packet traffic on both inputs checked cycle by cycle against a packet-level arbitration model.
module tb_stream_arb2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1_data, in2_data, out_data;
  logic       in1_valid, in1_last, in1_ready;
  logic       in2_valid, in2_last, in2_ready;
  logic       out_valid, out_last, out_ready, select;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus knobs (percentages / max packet length).
  int p_valid, p_rdy, p_rst, max_len;

  // Per-source stimulus: index 0 = in1, 1 = in2.
  int         left [2];
  logic       sv   [2];
  logic [7:0] sd   [2];
  logic       sl   [2];

  // Reference model: owner of an in-progress packet (0 none, 1/2 source),
  // last packet winner (1/2) and the single output slot.
  int         m_owner, m_last;
  logic       m_ov, m_ol, m_sel;
  logic [7:0] m_od;

  stream_arb2x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .in2_data  (in2_data),
    .in2_valid (in2_valid),
    .in2_last  (in2_last),
    .in2_ready (in2_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .select    (select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic new_beat(input int k);
    if (left[k] == 0) left[k] = $urandom_range(1, max_len);
    sv[k] = ($urandom_range(0, 99) < p_valid);
    sd[k] = 8'($urandom);
    sl[k] = (left[k] == 1);
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_ov    = 1'b0;
    m_ol    = 1'b0;
    m_sel   = 1'b0;
    m_od    = 8'h00;
  endtask

  task automatic drive();
    in1_valid = sv[0];
    in1_data  = sd[0];
    in1_last  = sl[0];
    in2_valid = sv[1];
    in2_data  = sd[1];
    in2_last  = sl[1];
  endtask

  task automatic cycle(input logic do_rst);
    int   g;
    int   k;
    logic ld, r1, r2, x1, x2;
    rst       = do_rst;
    out_ready = ($urandom_range(0, 99) < p_rdy);
    drive();
    @(negedge clk);
    if (m_owner != 0)          g = m_owner;
    else if (sv[0] && sv[1])   g = (m_last == 1) ? 2 : 1;
    else if (sv[0])            g = 1;
    else if (sv[1])            g = 2;
    else                       g = 0;
    ld = out_ready | ~m_ov;
    r1 = (g == 1) && ld && !do_rst;
    r2 = (g == 2) && ld && !do_rst;
    chk("in1_ready", 32'(in1_ready), 32'(r1));
    chk("in2_ready", 32'(in2_ready), 32'(r2));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("out_last",  32'(out_last),  32'(m_ol));
    chk("select",    32'(select),    32'(m_sel));
    x1 = sv[0] & r1;
    x2 = sv[1] & r2;
    if (do_rst) begin
      model_reset();
    end else if (x1 || x2) begin
      k     = x1 ? 0 : 1;
      m_od  = sd[k];
      m_ol  = sl[k];
      m_ov  = 1'b1;
      m_sel = (k == 1);
      if (sl[k]) begin
        m_owner = 0;
        m_last  = k + 1;
      end else begin
        m_owner = k + 1;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (do_rst) begin
        left[s] = 0;
        new_beat(s);
      end else if ((s == 0) ? x1 : x2) begin
        left[s]--;
        new_beat(s);
      end else if (!sv[s]) begin
        sv[s] = ($urandom_range(0, 99) < p_valid);
      end
    end
  endtask

  task automatic run_phase(input int n);
    for (int i = 0; i < n; i++) cycle($urandom_range(0, 99) < p_rst);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    p_valid   = 100;
    p_rdy     = 100;
    p_rst     = 0;
    max_len   = 1;
    left[0]   = 0;
    left[1]   = 0;
    new_beat(0);
    new_beat(1);
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset held with both inputs valid, then single-beat alternation.
    cycle(1'b1);
    cycle(1'b1);
    run_phase(20);
    // Multi-beat packets, always ready, both always valid.
    max_len = 4;
    run_phase(60);
    // Bubbles on inputs and random backpressure.
    p_valid = 60;
    p_rdy   = 60;
    run_phase(400);
    // Heavy backpressure.
    p_rdy = 20;
    run_phase(200);
    // Occasional reset mid-packet.
    p_rdy = 70;
    p_rst = 4;
    run_phase(400);
    p_rst = 0;
    p_valid = 100;
    p_rdy = 100;
    run_phase(40);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
